nios_audio_system_au_sched: RTL and testbench

Sample-pacing controller for the 16-bit audio output port. Nios writes PCM samples over an Avalon-MM slave into a small FIFO. A programmable divider releases exactly one sample per sample period onto out_port, with underrun and overflow tracking. It replaces direct CPU writes to the output PIO, so software timing jitter no longer reaches the codec path.

---
 rtl/nios_audio_system_au_sched_if.sv | 25 ++
 rtl/nios_audio_system_au_sched.sv | 259 +++++++++++++++++++++++++
 tb/tb_nios_audio_system_au_sched.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_audio_system_au_sched_if.sv
// Avalon-MM slave bus for the audio sample scheduler.
// master: Nios side driving the register accesses; slave: the scheduler.
interface nios_audio_system_au_sched_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_audio_system_au_sched.sv
// Audio sample scheduler: Nios pushes 16-bit PCM samples into a FIFO over
// Avalon-MM; a programmable divider releases one sample per period onto
// out_port, tracking underrun and overflow.
// Optional build macro AU_SCHED_IRQ_EN adds the irq output together with
// CONTROL[3] irq_en and CONTROL[15:8] level threshold.
module nios_audio_system_au_sched #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned LEVEL_W     = 5,
    parameter int unsigned DIV_DEFAULT = 1041
) (
    input  logic                               clk,
    input  logic                               reset,
    nios_audio_system_au_sched_if.slave        avs,
    output logic [15:0]                        out_port,
    output logic                               sample_strobe
`ifdef AU_SCHED_IRQ_EN
    ,
    output logic                               irq
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_DIVIDER = 2'd3;

    // Register state
    logic [15:0]        out_port_q,   out_port_d;
    logic               strobe_q,     strobe_d;
    logic [PTR_W-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,     rd_ptr_d;
    logic [LEVEL_W-1:0] level_q,      level_d;
    logic               underrun_q,   underrun_d;
    logic               overflow_q,   overflow_d;
    logic               enable_q,     enable_d;
    logic               hold_last_q,  hold_last_d;
    logic [15:0]        divider_q,    divider_d;
    logic [15:0]        counter_q,    counter_d;
`ifdef AU_SCHED_IRQ_EN
    logic               irq_en_q,     irq_en_d;
    logic [7:0]         threshold_q,  threshold_d;
    logic               irq_q,        irq_d;
`endif

    logic [15:0] fifo_mem [DEPTH];

    // Decoded bus events and FIFO control
    logic wr;
    logic wr_data;
    logic wr_status;
    logic wr_control;
    logic wr_divider;
    logic flush;
    logic tick;
    logic empty;
    logic full;
    logic pop;
    logic push_ok;
    logic underrun_set;
    logic overflow_set;

    logic unused_wdata_hi;
    assign unused_wdata_hi = ^avs.writedata[31:16];

    // Decode writes, divider tick and FIFO push/pop qualification
    always_comb begin
        wr         = avs.chipselect && !avs.write_n;
        wr_data    = wr && (avs.address == ADDR_DATA);
        wr_status  = wr && (avs.address == ADDR_STATUS);
        wr_control = wr && (avs.address == ADDR_CONTROL);
        wr_divider = wr && (avs.address == ADDR_DIVIDER);
        flush      = wr_control && avs.writedata[2];

        tick  = enable_q && (counter_q == '0);
        empty = (level_q == '0);
        full  = (level_q == LEVEL_W'(DEPTH));

        // Flush overrides both sides: the pending tick sees an empty FIFO
        // and any concurrent push is discarded.
        pop          = tick && !empty && !flush;
        push_ok      = wr_data && !flush && (!full || pop);
        overflow_set = wr_data && !flush && full && !pop;
        underrun_set = tick && (empty || flush);
    end

    // Next-state for the divider, FIFO bookkeeping, output and registers
    always_comb begin
        out_port_d  = out_port_q;
        strobe_d    = tick;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        underrun_d  = underrun_q;
        overflow_d  = overflow_q;
        enable_d    = enable_q;
        hold_last_d = hold_last_q;
        divider_d   = divider_q;
        counter_d   = counter_q;
`ifdef AU_SCHED_IRQ_EN
        irq_en_d    = irq_en_q;
        threshold_d = threshold_q;
`endif

        // Divider: a DIVIDER write reloads immediately, otherwise hold
        // while disabled, reload on tick, else count down.
        if (wr_divider) begin
            divider_d = avs.writedata[15:0];
            counter_d = avs.writedata[15:0];
        end else if (!enable_q || tick) begin
            counter_d = divider_q;
        end else begin
            counter_d = counter_q - 16'd1;
        end

        if (wr_control) begin
            enable_d    = avs.writedata[0];
            hold_last_d = avs.writedata[1];
`ifdef AU_SCHED_IRQ_EN
            irq_en_d    = avs.writedata[3];
            threshold_d = avs.writedata[15:8];
`endif
        end

        // Output sample on every tick: head of FIFO, or underrun fill
        if (tick) begin
            if (pop) begin
                out_port_d = fifo_mem[rd_ptr_q];
            end else if (!hold_last_q) begin
                out_port_d = '0;
            end
        end

        // FIFO pointers and level
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                level_d = level_q + LEVEL_W'(1);
            end else if (pop && !push_ok) begin
                level_d = level_q - LEVEL_W'(1);
            end
        end

        // Sticky flags: a new event wins over a software clear
        if (underrun_set) begin
            underrun_d = 1'b1;
        end else if (wr_status && avs.writedata[10]) begin
            underrun_d = 1'b0;
        end
        if (overflow_set) begin
            overflow_d = 1'b1;
        end else if (wr_status && avs.writedata[11]) begin
            overflow_d = 1'b0;
        end
    end

`ifdef AU_SCHED_IRQ_EN
    // Interrupt condition evaluated on current level/underrun state
    always_comb begin
        irq_d = irq_en_q &&
                ((9'(level_q) <= {1'b0, threshold_q}) || underrun_q);
    end
`endif

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            out_port_q  <= '0;
            strobe_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
            enable_q    <= 1'b0;
            hold_last_q <= 1'b0;
            divider_q   <= 16'(DIV_DEFAULT);
            counter_q   <= 16'(DIV_DEFAULT);
`ifdef AU_SCHED_IRQ_EN
            irq_en_q    <= 1'b0;
            threshold_q <= '0;
            irq_q       <= 1'b0;
`endif
        end else begin
            out_port_q  <= out_port_d;
            strobe_q    <= strobe_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
            enable_q    <= enable_d;
            hold_last_q <= hold_last_d;
            divider_q   <= divider_d;
            counter_q   <= counter_d;
`ifdef AU_SCHED_IRQ_EN
            irq_en_q    <= irq_en_d;
            threshold_q <= threshold_d;
            irq_q       <= irq_d;
`endif
        end
    end

    // Sample storage; contents are only meaningful below the level count
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= avs.writedata[15:0];
        end
    end

    // Combinational register read mux
    always_comb begin
        avs.readdata = '0;
        unique case (avs.address)
            ADDR_DATA: begin
                avs.readdata[15:0] = out_port_q;
            end
            ADDR_STATUS: begin
                // OR-merge: with DEPTH=256 level bit 8 overlaps empty, and
                // the two are never set together.
                avs.readdata[LEVEL_W-1:0] = level_q;
                avs.readdata[8]  = avs.readdata[8] | empty;
                avs.readdata[9]  = full;
                avs.readdata[10] = underrun_q;
                avs.readdata[11] = overflow_q;
            end
            ADDR_CONTROL: begin
                avs.readdata[0] = enable_q;
                avs.readdata[1] = hold_last_q;
`ifdef AU_SCHED_IRQ_EN
                avs.readdata[3]    = irq_en_q;
                avs.readdata[15:8] = threshold_q;
`endif
            end
            ADDR_DIVIDER: begin
                avs.readdata[15:0] = divider_q;
            end
            default: begin
                avs.readdata = '0;
            end
        endcase
    end

    assign out_port      = out_port_q;
    assign sample_strobe = strobe_q;
`ifdef AU_SCHED_IRQ_EN
    assign irq           = irq_q;
`endif

endmodule

// File: tb/tb_nios_audio_system_au_sched.sv
// Directed bench for the audio sample scheduler (DEPTH=16, DIV_DEFAULT=1041).
module tb_nios_audio_system_au_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] out_port;
    logic        sample_strobe;
`ifdef AU_SCHED_IRQ_EN
    logic        irq;
`endif

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    nios_audio_system_au_sched_if bus ();

    nios_audio_system_au_sched #(
        .DEPTH       (16),
        .LEVEL_W     (5),
        .DIV_DEFAULT (1041)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .avs           (bus.slave),
        .out_port      (out_port),
        .sample_strobe (sample_strobe)
`ifdef AU_SCHED_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One-cycle write, driven and released on falling edges
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    // Combinational read: no clock consumed
    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        bus.address = addr;
        #1;
        data = bus.readdata;
    endtask

    // Count falling edges until a strobe is seen; the gap is checked
    task automatic wait_strobe(input string tag, input int exp_gap);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_strobe && n < 64);
        check({tag, "_gap"}, 32'(n), 32'(exp_gap));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out"}, {16'h0, out_port}, 32'h0);
        check({tag, "_strobe"}, {31'h0, sample_strobe}, 32'h0);
        bus_read(2'd0, rd); check({tag, "_data"}, rd, 32'h0);
        bus_read(2'd1, rd); check({tag, "_status"}, rd, 32'h100);
        bus_read(2'd2, rd); check({tag, "_control"}, rd, 32'h0);
        bus_read(2'd3, rd); check({tag, "_divider"}, rd, 32'd1041);
`ifdef AU_SCHED_IRQ_EN
        check({tag, "_irq"}, {31'h0, irq}, 32'h0);
`endif
    endtask

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        reset          = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_state("rst0");

        // CONTROL readback of implemented bits only
        bus_write(2'd2, 32'h0000_FF0B);
        bus_read(2'd2, rd);
`ifdef AU_SCHED_IRQ_EN
        check("ctrl_rb", rd, 32'h0000_FF0B);
`else
        check("ctrl_rb", rd, 32'h0000_0003);
`endif
        bus_write(2'd2, 32'h0);

        // Pacing: DIVIDER=3 -> strobe every 4 cycles
        bus_write(2'd3, 32'd3);
        bus_read(2'd3, rd); check("div_rb", rd, 32'd3);
        bus_write(2'd0, 32'h1111);
        bus_write(2'd0, 32'h2222);
        bus_write(2'd0, 32'h3333);
        bus_read(2'd1, rd); check("pace_lvl3", rd, 32'h003);
        bus_write(2'd2, 32'h1);
        wait_strobe("pace1", 4); check("pace1_out", {16'h0, out_port}, 32'h1111);
        wait_strobe("pace2", 4); check("pace2_out", {16'h0, out_port}, 32'h2222);
        wait_strobe("pace3", 4); check("pace3_out", {16'h0, out_port}, 32'h3333);
        bus_read(2'd1, rd); check("pace_lvl0", rd, 32'h100);

        // Underrun with zero fill
        wait_strobe("und0", 4);
        check("und0_out", {16'h0, out_port}, 32'h0);
        bus_read(2'd1, rd); check("und0_status", rd, 32'h500);
        bus_write(2'd1, 32'h400);
        bus_read(2'd1, rd); check("und0_clear", rd, 32'h100);

        // Underrun with hold_last
        bus_write(2'd2, 32'h0);
        bus_write(2'd0, 32'hABCD);
        bus_write(2'd1, 32'h400);
        bus_write(2'd2, 32'h3);
        wait_strobe("hold1", 4);
        check("hold1_out", {16'h0, out_port}, 32'hABCD);
        bus_read(2'd1, rd); check("hold1_status", rd, 32'h100);
        wait_strobe("hold2", 4);
        check("hold2_out", {16'h0, out_port}, 32'hABCD);
        bus_read(2'd1, rd); check("hold2_status", rd, 32'h500);

        // Overflow: 18 pushes into a 16-deep FIFO while disabled
        bus_write(2'd2, 32'h0);
        bus_write(2'd1, 32'hC00);
        for (int i = 0; i < 18; i++) begin
            bus_write(2'd0, 32'h1000 + 32'(i));
        end
        bus_read(2'd1, rd); check("ovf_status", rd, 32'hA10);
        bus_write(2'd1, 32'h800);
        bus_read(2'd1, rd); check("ovf_clear", rd, 32'h210);
        bus_write(2'd2, 32'h1);
        for (int i = 0; i < 16; i++) begin
            wait_strobe($sformatf("ovf%0d", i), 4);
            check($sformatf("ovf%0d_out", i), {16'h0, out_port}, 32'h1000 + 32'(i));
        end
        bus_read(2'd1, rd); check("ovf_drained", rd, 32'h100);
        bus_write(2'd2, 32'h0);

`ifdef AU_SCHED_IRQ_EN
        // IRQ: threshold 2, drain from level 4
        for (int i = 0; i < 4; i++) begin
            bus_write(2'd0, 32'h3000 + 32'(i));
        end
        bus_write(2'd2, 32'h208);
        @(negedge clk);
        check("irq_lvl4", {31'h0, irq}, 32'h0);
        bus_write(2'd2, 32'h209);
        wait_strobe("irq_pop1", 4);
        @(negedge clk);
        check("irq_strobe_1cyc", {31'h0, sample_strobe}, 32'h0);
        check("irq_lvl3", {31'h0, irq}, 32'h0);
        wait_strobe("irq_pop2", 3);
        @(negedge clk);
        check("irq_lvl2", {31'h0, irq}, 32'h1);
        bus_write(2'd2, 32'h208);
        bus_write(2'd0, 32'h3100);
        @(negedge clk);
        check("irq_lvl3_again", {31'h0, irq}, 32'h0);
        bus_write(2'd2, 32'h4);
`endif

        // Simultaneous push and tick-pop with level 1, DIVIDER=0
        bus_write(2'd3, 32'h0);
        bus_write(2'd0, 32'h5555);
        bus_read(2'd1, rd); check("sim_lvl1_pre", rd, 32'h001);
        @(negedge clk);
        bus.address    = 2'd2;
        bus.writedata  = 32'h1;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.address    = 2'd0;
        bus.writedata  = 32'h6666;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus_read(2'd1, rd); check("sim_lvl1", rd, 32'h001);
        check("sim_out", {16'h0, out_port}, 32'h5555);
        // Flush coinciding with a tick: FIFO empties, tick is an underrun
        bus.address    = 2'd2;
        bus.writedata  = 32'h4;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus_read(2'd1, rd); check("flush_status", rd, 32'h500);
        check("flush_out", {16'h0, out_port}, 32'h0);
        bus_read(2'd2, rd); check("flush_ctrl", rd, 32'h0);

        // Push while full coinciding with a tick-pop: accepted, no overflow
        bus_write(2'd1, 32'hC00);
        for (int i = 0; i < 16; i++) begin
            bus_write(2'd0, 32'h2000 + 32'(i));
        end
        bus_read(2'd1, rd); check("full_pre", rd, 32'h210);
        @(negedge clk);
        bus.address    = 2'd2;
        bus.writedata  = 32'h1;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.address    = 2'd0;
        bus.writedata  = 32'h7777;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus_read(2'd1, rd); check("full_pushpop", rd, 32'h210);
        check("full_out", {16'h0, out_port}, 32'h2000);

        // Reset while streaming
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("rst1");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
